// File: rtl/toy_ctrl_pkg.sv
// Shared opcode, ALU and state encodings for the ToyProcessor control unit.
package toy_ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_OUT = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        HALT    = 3'd4
    } state_t;

endpackage

// File: rtl/toy_decode.sv
// Combinational strobe decode from (state, latched opcode, Zero) for the control unit.
module toy_decode
    import toy_ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic       pc_load,
    output logic       pc_inc,
    output logic       ir_load,
    output logic       a_load,
    output logic       b_load,
    output logic       out_load,
    output logic       a_sel,
    output logic [1:0] alu_op,
    output logic       busy,
    output logic       halted,
    output logic       illegal
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        ir_load  = 1'b0;
        a_load   = 1'b0;
        b_load   = 1'b0;
        out_load = 1'b0;
        a_sel    = 1'b0;
        alu_op   = ALU_ADD;
        busy     = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (st)
            FETCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
                busy    = 1'b1;
            end
            DECODE: busy = 1'b1;
            EXECUTE: begin
                busy = 1'b1;
                case (opcode)
                    OP_NOP, OP_HLT: ;
                    OP_LDA: a_load = 1'b1;
                    OP_LDB: b_load = 1'b1;
                    OP_ADD: begin a_load = 1'b1; a_sel = 1'b1; alu_op = ALU_ADD; end
                    OP_SUB: begin a_load = 1'b1; a_sel = 1'b1; alu_op = ALU_SUB; end
                    OP_AND: begin a_load = 1'b1; a_sel = 1'b1; alu_op = ALU_AND; end
                    OP_OR:  begin a_load = 1'b1; a_sel = 1'b1; alu_op = ALU_OR;  end
                    OP_OUT: out_load = 1'b1;
                    OP_JMP: pc_load = 1'b1;
                    // Zero comes straight from the ALU in this same cycle
                    OP_JZ:  pc_load = zero;
                    default: illegal = 1'b1;
                endcase
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/toy_control_unit.sv
// Three-cycle fetch/decode/execute sequencer: state, latched instruction fields and retired count.
module toy_control_unit
    import toy_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic [DATA_W-1:0]        IR_Q,
    input  logic                     Zero,
    output logic                     PC_Load,
    output logic                     PC_Inc,
    output logic                     IR_Load,
    output logic                     A_Load,
    output logic                     B_Load,
    output logic                     Out_Load,
    output logic                     A_Sel,
    output logic [1:0]               ALU_Op,
    output logic [DATA_W-OP_W-1:0]   Operand,
    output logic                     Busy,
    output logic                     Halted,
    output logic                     Illegal,
    output logic [CNT_W-1:0]         Instr_Count
);

    state_t                  state_q;
    state_t                  state_d;
    logic [OP_W-1:0]         opcode_q;
    logic [DATA_W-OP_W-1:0]  operand_q;
    logic [CNT_W-1:0]        count_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            opcode_q  <= '0;
            operand_q <= '0;
            count_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                opcode_q  <= IR_Q[DATA_W-1 -: OP_W];
                operand_q <= IR_Q[DATA_W-OP_W-1:0];
            end
            // Every EXECUTE exit retires one instruction, HLT and illegal included
            if (state_q == EXECUTE)
                count_q <= count_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = Start ? FETCH : IDLE;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = EXECUTE;
            EXECUTE: state_d = (opcode_q == OP_HLT) ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    toy_decode u_decode (
        .state    (state_q),
        .opcode   (opcode_q),
        .zero     (Zero),
        .pc_load  (PC_Load),
        .pc_inc   (PC_Inc),
        .ir_load  (IR_Load),
        .a_load   (A_Load),
        .b_load   (B_Load),
        .out_load (Out_Load),
        .a_sel    (A_Sel),
        .alu_op   (ALU_Op),
        .busy     (Busy),
        .halted   (Halted),
        .illegal  (Illegal)
    );

    assign Operand     = operand_q;
    assign Instr_Count = count_q;

endmodule
